// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin share of one FIFO write port.
// Optional packet lock enabled by defining FIFO_ARB_PACKET_LOCK_EN.
module fifo_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int W         = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ*W-1:0] data,
   input  logic [N_REQ-1:0] last,
   input  logic             full,
   output logic [N_REQ-1:0] gnt,
   output logic             push,
   output logic [W-1:0]     wdata,
   output logic             busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {IDLE, LOCKED} st_e;

   st_e           st_q, st_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] rr_sel;
   logic          rr_hit;
   logic [PW-1:0] sel;
   logic [PW-1:0] sel_nxt;
   logic          found;
   logic          take;

`ifdef FIFO_ARB_PACKET_LOCK_EN
   localparam int BW = $clog2(MAX_BEATS + 1);
   logic [PW-1:0] owner_q, owner_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [BW-1:0] beats_inc;
`else
   logic          unused_last;
   assign unused_last = ^last;
`endif

   function automatic logic [PW-1:0] wrap_add(
      input logic [PW-1:0] a,
      input int            k
   );
      int s;
      s = (int'(a) + k) % N_REQ;
      return PW'(s);
   endfunction

   // Round-robin search starting at rr_ptr
   always_comb begin
      rr_sel = '0;
      rr_hit = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!rr_hit && req[wrap_add(rr_ptr_q, k)]) begin
            rr_hit = 1'b1;
            rr_sel = wrap_add(rr_ptr_q, k);
         end
      end
   end

   // Grant, write data and busy outputs
   always_comb begin
      sel   = rr_sel;
      found = rr_hit;
`ifdef FIFO_ARB_PACKET_LOCK_EN
      if (st_q == LOCKED) begin
         sel   = owner_q;
         found = req[owner_q];
      end
`endif
      take  = found & ~full & ~rst;
      gnt   = '0;
      wdata = '0;
      if (take) begin
         gnt[sel] = 1'b1;
         wdata    = data[int'(sel)*W +: W];
      end
      push    = take;
      busy    = (st_q == LOCKED) & ~rst;
      sel_nxt = wrap_add(sel, 1);
   end

   // Next-state: pointer advance and packet lock tracking
   always_comb begin
      st_d     = st_q;
      rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_PACKET_LOCK_EN
      owner_d   = owner_q;
      beats_d   = beats_q;
      beats_inc = beats_q + 1'b1;
      if (take) begin
         unique case (st_q)
            IDLE: begin
               if (!last[sel] && MAX_BEATS > 1) begin
                  st_d    = LOCKED;
                  owner_d = sel;
                  beats_d = BW'(1);
               end else begin
                  rr_ptr_d = sel_nxt;
               end
            end
            LOCKED: begin
               if (last[sel] || beats_inc == BW'(MAX_BEATS)) begin
                  st_d     = IDLE;
                  beats_d  = '0;
                  rr_ptr_d = sel_nxt;
               end else begin
                  beats_d = beats_inc;
               end
            end
         endcase
      end
`else
      if (take) begin
         rr_ptr_d = sel_nxt;
      end
`endif
   end

   // State and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= IDLE;
         rr_ptr_q <= '0;
      end else begin
         st_q     <= st_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef FIFO_ARB_PACKET_LOCK_EN
   // Lock owner and beat counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= '0;
         beats_q <= '0;
      end else begin
         owner_q <= owner_d;
         beats_q <= beats_d;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random checks
// against a queue-free behavioural arbitration model.
module tb_fifo_write_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  last;
   logic        full;
   logic [3:0]  gnt;
   logic        push;
   logic [7:0]  wdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int m_ptr    = 0;
   int m_owner  = 0;
   int m_beats  = 0;
   bit m_locked = 1'b0;

   fifo_write_arbiter #(
      .N_REQ(4),
      .W(8),
      .MAX_BEATS(MAXB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .data(data),
      .last(last),
      .full(full),
      .gnt(gnt),
      .push(push),
      .wdata(wdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic bitof(input logic [3:0] v, input int i);
      logic [3:0] t;
      t = v >> i;
      return t[0];
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model.
   task automatic cyc(input string tag, input int want = -1);
      int          g;
      logic [3:0]  eg;
      logic [31:0] sh;
      logic [7:0]  ew;
      @(negedge clk);
      g = -1;
      if (!rst && !full) begin
         if (m_locked) begin
            if (bitof(req, m_owner)) g = m_owner;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && bitof(req, (m_ptr + k) % 4))
                  g = (m_ptr + k) % 4;
            end
         end
      end
      eg = '0;
      ew = '0;
      if (g >= 0) begin
         eg = 4'b0001 << g;
         sh = data >> (8 * g);
         ew = sh[7:0];
      end
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_push"}, 32'(push), 32'(g >= 0));
      chk({tag, "_wdata"}, 32'(wdata), 32'(ew));
      chk({tag, "_busy"}, 32'(busy), 32'(m_locked && !rst));
      if (want >= 0) chk({tag, "_spec"}, 32'(gnt), 32'(want));
      @(posedge clk);
      if (rst) begin
         m_ptr    = 0;
         m_owner  = 0;
         m_beats  = 0;
         m_locked = 1'b0;
      end else if (g >= 0) begin
`ifdef FIFO_ARB_PACKET_LOCK_EN
         if (m_locked) begin
            m_beats++;
            if (bitof(last, g) || m_beats == MAXB) begin
               m_locked = 1'b0;
               m_beats  = 0;
               m_ptr    = (g + 1) % 4;
            end
         end else if (!bitof(last, g)) begin
            m_locked = 1'b1;
            m_owner  = g;
            m_beats  = 1;
         end else begin
            m_ptr = (g + 1) % 4;
         end
`else
         m_ptr = (g + 1) % 4;
`endif
      end
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      req  = 4'b1111;
      last = 4'b1111;
      full = 1'b0;
      data = 32'h44332211;
      cyc("rst", 0);
      cyc("rst", 0);
      rst = 1'b0;
      cyc("post_rst", 1);
      cyc("rot", 2);
      cyc("rot", 4);
      cyc("rot", 8);
      cyc("rot", 1);

      req  = 4'b0100;
      full = 1'b1;
      repeat (3) cyc("full", 0);
      full = 1'b0;
      cyc("unfull", 4);

`ifdef FIFO_ARB_PACKET_LOCK_EN
      rst = 1'b1;
      cyc("rst4", 0);
      rst  = 1'b0;
      req  = 4'b0011;
      last = 4'b0000;
      cyc("pkt_b1", 1);
      cyc("pkt_b2", 1);
      last = 4'b0001;
      cyc("pkt_b3", 1);
      last = 4'b0000;
      cyc("pkt_next", 2);

      rst = 1'b1;
      cyc("rst5", 0);
      rst = 1'b0;
      req = 4'b0010;
      repeat (4) cyc("limit", 2);
      req = 4'b0110;
      cyc("limit_after", 4);

      rst = 1'b1;
      cyc("rst6", 0);
      rst = 1'b0;
      req = 4'b0100;
      cyc("own2", 4);
      req = 4'b0001;
      repeat (5) cyc("mask", 0);
      req  = 4'b1101;
      last = 4'b0100;
      cyc("own2_last", 4);
      req  = 4'b1001;
      last = 4'b1111;
      cyc("after_own2", 8);
`endif

      for (int n = 0; n < 400; n++) begin
         rst  = ($urandom % 50) == 0;
         req  = 4'($urandom);
         last = 4'($urandom);
         full = ($urandom % 4) == 0;
         data = $urandom;
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
